// File: rtl/pratica_6_sequencer.sv
// -----------------------------------------------------------------------------
// pratica_6_sequencer
// Self-test controller for the practice-6 datapath. When started, it drives
// every input vector {M1,M2,M3,M4} from 0 to 15 in order. Each vector is held
// for DWELL_CYCLES cycles, and then the datapath response is sampled in a
// single cycle. Each response is compared with the golden nibble for that
// vector. At the end of the sweep the block reports the error count, the
// first failing vector and a pass flag.
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst_n          synchronous active-low reset
//   i_start          level; accepted only in IDLE or DONE
//   i_abort          level; returns to IDLE, has priority over i_start
//   o_m_out[3:0]     datapath inputs {M1,M2,M3,M4}, M1 = bit 3
//   i_s_in[3:0]      datapath outputs {S1,S2,S3,S4}, S1 = bit 3
//   o_busy           sweep in progress
//   o_sample_strobe  one-cycle pulse during each SAMPLE cycle
//   o_done           sweep finished, results valid
//   o_pass           err_count == 0 (meaningful while o_done)
//   o_err_count[4:0] number of mismatching vectors, 0..16
//   o_fail_vec[3:0]  first mismatching vector
//   o_fail_valid     o_fail_vec holds a captured value
// -----------------------------------------------------------------------------
module pratica_6_sequencer #(
    parameter int          DWELL_CYCLES = 10,
    parameter logic [63:0] EXPECTED     = 64'hFEDC_BA98_7654_3210
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    output logic [3:0] o_m_out,
    input  logic [3:0] i_s_in,
    output logic       o_busy,
    output logic       o_sample_strobe,
    output logic       o_done,
    output logic       o_pass,
    output logic [4:0] o_err_count,
    output logic [3:0] o_fail_vec,
    output logic       o_fail_valid
);

    localparam int             DW         = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SAMPLE, ST_DONE} state_t;

    state_t        r_state, w_state_nx;
    logic [3:0]    r_vec, w_vec_nx;
    logic [DW-1:0] r_dwell, w_dwell_nx;
    logic [4:0]    r_err, w_err_nx;
    logic [3:0]    r_fail_vec, w_fail_vec_nx;
    logic          r_fail_valid, w_fail_valid_nx;
    logic [3:0]    r_m_out, w_m_out_nx;
    logic          r_busy, w_busy_nx;
    logic          r_strobe, w_strobe_nx;
    logic          r_done, w_done_nx;
    logic          r_pass, w_pass_nx;

    logic w_accept;
    logic w_mismatch;

    assign w_accept   = i_start && !i_abort && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_mismatch = (i_s_in != EXPECTED[{r_vec, 2'b00} +: 4]);

    // State and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_vec        <= '0;
            r_dwell      <= '0;
            r_err        <= '0;
            r_fail_vec   <= '0;
            r_fail_valid <= 1'b0;
            r_m_out      <= '0;
            r_busy       <= 1'b0;
            r_strobe     <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_vec        <= w_vec_nx;
            r_dwell      <= w_dwell_nx;
            r_err        <= w_err_nx;
            r_fail_vec   <= w_fail_vec_nx;
            r_fail_valid <= w_fail_valid_nx;
            r_m_out      <= w_m_out_nx;
            r_busy       <= w_busy_nx;
            r_strobe     <= w_strobe_nx;
            r_done       <= w_done_nx;
            r_pass       <= w_pass_nx;
        end
    end

    // Next-state logic. Abort overrides everything else.
    always_comb begin
        w_state_nx = r_state;
        if (i_abort) begin
            w_state_nx = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (i_start) w_state_nx = ST_WAIT;
                ST_WAIT:          if (r_dwell == DWELL_LAST) w_state_nx = ST_SAMPLE;
                ST_SAMPLE:        w_state_nx = (r_vec == 4'hF) ? ST_DONE : ST_WAIT;
                default:          w_state_nx = ST_IDLE;
            endcase
        end
    end

    // Output logic. This block computes the next value of every register
    // except the state. The output flags are decoded from the next state, so
    // they change on the same edge as the state they describe.
    always_comb begin
        w_vec_nx        = r_vec;
        w_dwell_nx      = r_dwell;
        w_err_nx        = r_err;
        w_fail_vec_nx   = r_fail_vec;
        w_fail_valid_nx = r_fail_valid;
        if (w_accept) begin
            w_vec_nx        = '0;
            w_dwell_nx      = '0;
            w_err_nx        = '0;
            w_fail_vec_nx   = '0;
            w_fail_valid_nx = 1'b0;
        end else if (i_abort) begin
            // Results are held; only the sweep position is cleared.
            w_vec_nx   = '0;
            w_dwell_nx = '0;
        end else begin
            case (r_state)
                ST_WAIT: w_dwell_nx = r_dwell + 1'b1;
                ST_SAMPLE: begin
                    if (w_mismatch) begin
                        w_err_nx = r_err + 5'd1;
                        if (!r_fail_valid) begin
                            w_fail_vec_nx   = r_vec;
                            w_fail_valid_nx = 1'b1;
                        end
                    end
                    if (r_vec != 4'hF) begin
                        w_vec_nx   = r_vec + 4'd1;
                        w_dwell_nx = '0;
                    end
                end
                default: ;
            endcase
        end

        w_busy_nx   = (w_state_nx == ST_WAIT) || (w_state_nx == ST_SAMPLE);
        w_strobe_nx = (w_state_nx == ST_SAMPLE);
        w_done_nx   = (w_state_nx == ST_DONE);
        // pass includes the final vector-15 comparison because it uses w_err_nx.
        w_pass_nx   = w_done_nx && (w_err_nx == 5'd0);
        w_m_out_nx  = w_busy_nx ? w_vec_nx : 4'h0;
    end

    assign o_m_out         = r_m_out;
    assign o_busy          = r_busy;
    assign o_sample_strobe = r_strobe;
    assign o_done          = r_done;
    assign o_pass          = r_pass;
    assign o_err_count     = r_err;
    assign o_fail_vec      = r_fail_vec;
    assign o_fail_valid    = r_fail_valid;

endmodule

// File: tb/tb_pratica_6_sequencer.sv
module tb_pratica_6_sequencer;

    localparam int D   = 2;
    localparam int PER = D + 1;

    logic       i_clk = 1'b0;
    logic       i_rst_n, i_start, i_abort;
    logic [3:0] o_m_out, i_s_in;
    logic       o_busy, o_sample_strobe, o_done, o_pass, o_fail_valid;
    logic [4:0] o_err_count;
    logic [3:0] o_fail_vec;

    int mode = 0;     // 0: s_in = m_out, 1: fault at vector 6, 2: s_in = ~m_out
    int checks = 0;
    int failures = 0;

    pratica_6_sequencer #(.DWELL_CYCLES(D)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
        .o_m_out(o_m_out), .i_s_in(i_s_in), .o_busy(o_busy),
        .o_sample_strobe(o_sample_strobe), .o_done(o_done), .o_pass(o_pass),
        .o_err_count(o_err_count), .o_fail_vec(o_fail_vec), .o_fail_valid(o_fail_valid)
    );

    always #5 i_clk = ~i_clk;

    // Datapath model: the identity by default, so the golden table matches.
    always_comb begin
        case (mode)
            0:       i_s_in = o_m_out;
            1:       i_s_in = (o_m_out == 4'h6) ? 4'h0 : o_m_out;
            default: i_s_in = ~o_m_out;
        endcase
    end

    // {m_out, busy, strobe, done, pass, err_count, fail_vec, fail_valid}
    function automatic logic [17:0] outs();
        return {o_m_out, o_busy, o_sample_strobe, o_done, o_pass,
                o_err_count, o_fail_vec, o_fail_valid};
    endfunction

    function automatic logic [17:0] mk(input logic [3:0] m, input logic b, s, d, p,
                                       input logic [4:0] e, input logic [3:0] fv,
                                       input logic fvl);
        return {m, b, s, d, p, e, fv, fvl};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        abort;
        logic [17:0] exp;
    } vec_t;

    // One sweep with start accepted at the first edge. j counts the edges
    // after the acceptance edge k. The flags are checked at edges k..k+47,
    // and the results are checked at edge k+48.
    task automatic sweep(input string tag, input logic hold, input logic [4:0] e_err,
                         input logic [3:0] e_fv, input logic e_fvl, input logic e_pass);
        int strobes = 0;
        int bad = 0;
        i_start = 1'b1;
        for (int j = 0; j < 16 * PER; j++) begin
            tick();
            i_start = hold;
            if (o_sample_strobe) strobes++;
            if (o_m_out !== 4'(j / PER) || o_sample_strobe !== (j % PER == PER - 1) ||
                o_busy !== 1'b1 || o_done !== 1'b0) bad++;
        end
        chk({tag, "_flow_errs"}, bad, 0);
        chk({tag, "_strobes"}, strobes, 16);
        tick();
        chk({tag, "_done"}, outs(), mk(4'h0, 0, 0, 1, e_pass, e_err, e_fv, e_fvl));
    endtask

    vec_t tbl[13];

    initial begin
        // Reset, start while in reset, acceptance, first vectors, a start
        // that is ignored while busy, abort, abort winning over start, restart.
        tbl[0]  = '{0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{1, 1, 0, mk(0, 1, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{1, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{1, 0, 0, mk(0, 1, 1, 0, 0, 0, 0, 0)};
        tbl[6]  = '{1, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{1, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0)};
        tbl[8]  = '{1, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 0)};
        tbl[9]  = '{1, 1, 0, mk(2, 1, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[11] = '{1, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[12] = '{1, 1, 0, mk(0, 1, 0, 0, 0, 0, 0, 0)};

        i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
        for (int i = 0; i < 13; i++) begin
            i_rst_n = tbl[i].rst_n; i_start = tbl[i].start; i_abort = tbl[i].abort;
            tick();
            chk($sformatf("tbl%0d", i), outs(), tbl[i].exp);
        end

        // Return to IDLE before the sweeps.
        i_start = 1'b0; i_abort = 1'b1;
        tick();
        i_abort = 1'b0;

        mode = 0; sweep("clean", 1'b0, 5'd0, 4'h0, 1'b0, 1'b1);
        tick();
        chk("done_hold", outs(), mk(0, 0, 0, 1, 1, 0, 0, 0));

        mode = 1; sweep("fault6", 1'b0, 5'd1, 4'h6, 1'b1, 1'b0);
        mode = 2; sweep("allbad", 1'b0, 5'h10, 4'h0, 1'b1, 1'b0);

        // Restarting clears the results on the acceptance edge.
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("restart_clear", outs(), mk(0, 1, 0, 0, 0, 0, 0, 0));

        // Still mode 2. Run to vector 5 (edge k+15), then abort. Vectors 0..4
        // have been sampled and all mismatched.
        for (int j = 1; j <= 5 * PER; j++) tick();
        chk("at_vec5", o_m_out, 4'h5);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort", outs(), mk(0, 0, 0, 0, 0, 5, 0, 1));
        tick();
        chk("abort_idle", outs(), mk(0, 0, 0, 0, 0, 5, 0, 1));
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("abort_restart", outs(), mk(0, 1, 0, 0, 0, 0, 0, 0));
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;

        // Hold start high through a whole sweep. The sweep must not restart
        // early, and a new sweep must be accepted on the first edge in DONE.
        mode = 0; sweep("held", 1'b1, 5'd0, 4'h0, 1'b0, 1'b1);
        mode = 2;
        tick();
        chk("held_reaccept", outs(), mk(0, 1, 0, 0, 0, 0, 0, 0));
        i_start = 1'b0;
        for (int j = 1; j <= 9 * PER + 1; j++) tick();
        chk("at_vec9", {o_m_out, o_err_count}, {4'h9, 5'd9});
        i_rst_n = 1'b0;
        tick();
        chk("midsweep_reset", outs(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        i_rst_n = 1'b1;
        tick();
        chk("post_reset_idle", outs(), mk(0, 0, 0, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
